spi_master_ctrl: RTL and testbench

SPI initiator that drives the team's SPI slave/RAM block from the other end of the serial link. It accepts one 10-bit RAM command per transaction on a parallel valid/ready port, serialises it on MOSI with the slave's command-check prefix bit, and for read-data commands (`2'b01`) clocks the 8-bit RAM reply back in on MISO. It is used as the bus-side front end in system tests and as the initiator model for the SPI slave.

---
 rtl/spi_master_ctrl.sv | 138 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI initiator (mode 0) for the SPI slave/RAM block: one 10-bit RAM command per
// frame with a write/read prefix bit, plus an 8-bit reply capture for read-data commands.
`timescale 1ns/1ps

// state    | meaning
// S_IDLE   | ready for a command, link idle
// S_SELECT | ss_n low, prefix bit on mosi, one clk of setup
// S_TX     | 11 command bits shifted out MSB first
// S_TURN   | dummy pulses covering the RAM reply latency
// S_RX     | 8 reply bits sampled on sclk rise
// S_DESEL  | ss_n high gap, reply published on entry

module spi_master_ctrl #(
   parameter int CLK_DIV     = 2,
   parameter int TURN_PULSES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [9:0] cmd_din,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic       sclk,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_TX     = 3'd2;
   localparam logic [2:0] S_TURN   = 3'd3;
   localparam logic [2:0] S_RX     = 3'd4;
   localparam logic [2:0] S_DESEL  = 3'd5;

   localparam logic [8:0] DIV_LOAD   = 9'(CLK_DIV - 1);
   localparam logic [8:0] DESEL_LOAD = 9'(2 * CLK_DIV - 1);
   localparam logic [4:0] TX_LOAD    = 5'd21;
   localparam logic [4:0] RX_LOAD    = 5'd15;
   localparam logic [4:0] TURN_LOAD  = (TURN_PULSES > 0) ? 5'(2 * TURN_PULSES - 1) : 5'd0;

   logic [2:0]  state;
   logic [10:0] shreg;
   logic [1:0]  op;
   logic [7:0]  rx_shreg;
   logic [8:0]  div_cnt;
   logic [4:0]  half_cnt;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = ~cmd_ready;
   // shreg is cleared outside TX, so mosi is a flop output that idles low
   assign mosi      = shreg[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         shreg    <= 11'd0;
         op       <= 2'd0;
         rx_shreg <= 8'd0;
         div_cnt  <= 9'd0;
         half_cnt <= 5'd0;
         sclk     <= 1'b0;
         ss_n     <= 1'b1;
         rd_data  <= 8'd0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  shreg <= {cmd_din[9], cmd_din};
                  op    <= cmd_din[9:8];
                  ss_n  <= 1'b0;
                  state <= S_SELECT;
               end
            end
            S_SELECT: begin
               div_cnt  <= DIV_LOAD;
               half_cnt <= TX_LOAD;
               state    <= S_TX;
            end
            S_TX, S_TURN, S_RX: begin
               if (div_cnt != 9'd0) begin
                  div_cnt <= div_cnt - 9'd1;
               end else begin
                  div_cnt <= DIV_LOAD;
                  sclk    <= ~sclk;
                  if (half_cnt != 5'd0) half_cnt <= half_cnt - 5'd1;
                  if (!sclk) begin
                     if (state == S_RX) rx_shreg <= {rx_shreg[6:0], miso};
                  end else if (half_cnt != 5'd0) begin
                     if (state == S_TX) shreg <= {shreg[9:0], 1'b0};
                  end else begin
                     // last falling edge of the phase
                     case (state)
                        S_TX: begin
                           shreg <= 11'd0;
                           if (op == 2'b01) begin
                              if (TURN_PULSES > 0) begin
                                 state    <= S_TURN;
                                 half_cnt <= TURN_LOAD;
                              end else begin
                                 state    <= S_RX;
                                 half_cnt <= RX_LOAD;
                              end
                           end else begin
                              state   <= S_DESEL;
                              ss_n    <= 1'b1;
                              div_cnt <= DESEL_LOAD;
                           end
                        end
                        S_TURN: begin
                           state    <= S_RX;
                           half_cnt <= RX_LOAD;
                        end
                        default: begin
                           state    <= S_DESEL;
                           ss_n     <= 1'b1;
                           div_cnt  <= DESEL_LOAD;
                           rd_data  <= rx_shreg;
                           rd_valid <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            S_DESEL: begin
               if (div_cnt != 9'd0) div_cnt <= div_cnt - 9'd1;
               else                 state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized bench for spi_master_ctrl: SPI slave/RAM model on the serial side,
// command-level RAM reference feeding a read-data scoreboard, frame timing monitor.
`timescale 1ns/1ps

module tb_spi_master_ctrl;
   localparam int D       = 1;
   localparam int T       = 1;
   localparam int LEN_CMD = 1 + 24 * D;
   localparam int LEN_RD  = 1 + (40 + 2 * T) * D;
   localparam int RDV_AT  = LEN_RD - 2 * D;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [9:0] cmd_din = 10'd0;
   logic       miso = 1'b0;
   logic       cmd_ready, rd_valid, busy, sclk, ss_n, mosi;
   logic [7:0] rd_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   spi_master_ctrl #(.CLK_DIV(D), .TURN_PULSES(T)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_din   (cmd_din),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .sclk      (sclk),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .miso      (miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // command-level RAM reference: read-data commands push the byte they must return
   bit [7:0]   ref_mem [256];
   bit [7:0]   ref_raddr, ref_waddr;
   logic [7:0] exp_q [$];

   function automatic void ref_apply(input logic [9:0] c);
      case (c[9:8])
         2'b00:   ref_raddr = c[7:0];
         2'b01:   exp_q.push_back(ref_mem[ref_raddr]);
         2'b10:   ref_waddr = c[7:0];
         default: ref_mem[ref_waddr] = c[7:0];
      endcase
   endfunction

   // SPI slave/RAM on the far end of the link
   bit [7:0]    s_mem [256];
   bit [7:0]    s_raddr, s_waddr, s_tx;
   int          s_rises = 0;
   logic [10:0] s_bits = 11'd0;

   always @(negedge ss_n or posedge sclk) begin
      if (!sclk) s_rises <= 0;
      else if (!ss_n) begin
         s_rises <= s_rises + 1;
         if (s_rises < 11) s_bits <= {s_bits[9:0], mosi};
         if (s_rises == 10) begin
            case (s_bits[8:7])
               2'b00:   s_raddr <= {s_bits[6:0], mosi};
               2'b01:   s_tx <= s_mem[s_raddr];
               2'b10:   s_waddr <= {s_bits[6:0], mosi};
               default: s_mem[s_waddr] <= {s_bits[6:0], mosi};
            endcase
         end
      end
   end

   always @(negedge sclk) begin
      if (!ss_n && s_rises >= 11 + T && s_rises < 19 + T) miso <= s_tx[3'(18 + T - s_rises)];
   end

   // frame monitor: timing, serialised bits, pulse counts, ss_n gaps
   logic        in_frame = 1'b0, prev_sclk = 1'b0, prev_ss = 1'b1;
   logic        have_rise = 1'b0, b2b = 1'b0, mosi_bad = 1'b0;
   int          acc_cyc = 0, rises = 0, ss_rise_cyc = 0;
   logic [9:0]  fr_cmd = 10'd0;
   logic [10:0] mosi_bits = 11'd0;
   logic [7:0]  last_rd = 8'd0;
   logic        prev_rdv = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame  <= 1'b0;
         prev_sclk <= 1'b0;
         prev_ss   <= 1'b1;
         have_rise <= 1'b0;
         b2b       <= 1'b0;
      end else begin
         prev_sclk <= sclk;
         prev_ss   <= ss_n;
         if (ss_n && !prev_ss) begin
            ss_rise_cyc <= cyc;
            have_rise   <= 1'b1;
         end
         if (!ss_n && prev_ss && have_rise) begin
            if (b2b) chk("ss_gap_b2b", cyc - ss_rise_cyc, 2 * D + 1);
            else     chk("ss_gap_min", int'(cyc - ss_rise_cyc >= 2 * D + 1), 1);
         end
         if (in_frame) begin
            if (cyc == acc_cyc) begin
               chk("select_ss_n", int'(ss_n), 0);
               chk("select_mosi_prefix", int'(mosi), int'(fr_cmd[9]));
               chk("busy_in_frame", int'(busy), 1);
            end
            if (sclk && !prev_sclk) begin
               rises <= rises + 1;
               if (rises == 0) chk("first_rise_t", cyc - acc_cyc, 1 + D);
               if (rises < 11) mosi_bits <= {mosi_bits[9:0], mosi};
               else if (mosi)  mosi_bad <= 1'b1;
            end
            if (rd_valid) chk("rd_valid_t", cyc - acc_cyc, RDV_AT);
            if (cmd_ready) begin
               chk("frame_len", cyc - acc_cyc, (fr_cmd[9:8] == 2'b01) ? LEN_RD : LEN_CMD);
               chk("mosi_bits", int'(mosi_bits), int'({fr_cmd[9], fr_cmd}));
               chk("sclk_pulses", rises, (fr_cmd[9:8] == 2'b01) ? 19 + T : 11);
               chk("mosi_low_after_cmd", int'(mosi_bad), 0);
               chk("rd_data_hold", int'(rd_data), int'(last_rd));
               in_frame <= 1'b0;
            end
         end
         if (cmd_valid && cmd_ready) begin
            b2b       <= in_frame;
            in_frame  <= 1'b1;
            acc_cyc   <= cyc + 1;
            fr_cmd    <= cmd_din;
            rises     <= 0;
            mosi_bits <= 11'd0;
            mosi_bad  <= 1'b0;
         end
      end
   end

   // scoreboard monitor for the read-data reply
   always @(negedge clk) begin
      prev_rdv <= rd_valid && rst_n;
      if (!rst_n) last_rd <= 8'd0;
      else if (rd_valid) begin
         last_rd <= rd_data;
         chk("rd_valid_width", int'(prev_rdv), 0);
         if (exp_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
         else begin
            chk("rd_data", int'(rd_data), int'(exp_q[0]));
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic [9:0] c);
      int n = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_din   = c;
      while (!cmd_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         chk("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_din   = 10'($urandom);
      ref_apply(c);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      logic [7:0] a, d;
      int n, r;
      logic ps;

      repeat (3) @(negedge clk);
      chk("rst_ss_n", int'(ss_n), 1);
      chk("rst_sclk", int'(sclk), 0);
      chk("rst_mosi", int'(mosi), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      issue(10'b10_0101_1010);
      wait_idle();

      issue({2'b10, 8'h11});
      issue({2'b11, 8'hA5});
      issue({2'b00, 8'h11});
      issue({2'b01, 8'h5C});
      issue({2'b10, 8'h3C});
      issue({2'b11, 8'h7E});
      issue({2'b00, 8'h3C});
      issue({2'b01, 8'h00});

      for (int i = 0; i < 50; i++) begin
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            repeat ($urandom_range(1, 4)) @(posedge clk);
         end
         issue({2'b10, a});
         issue({2'b11, d});
         issue({2'b00, a});
         issue({2'b01, 8'($urandom)});
      end

      // abort a read-data frame after its 5th sclk rise
      issue({2'b01, 8'h00});
      n  = 0;
      r  = 0;
      ps = 1'b0;
      while (r < 5 && n < 300) begin
         @(negedge clk);
         if (sclk && !ps) r++;
         ps = sclk;
         n++;
      end
      chk("abort_reached_rise5", r, 5);
      chk("abort_sclk_high_before", int'(sclk), 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_ss_n", int'(ss_n), 1);
      chk("abort_sclk", int'(sclk), 0);
      chk("abort_mosi", int'(mosi), 0);
      chk("abort_rd_valid", int'(rd_valid), 0);
      chk("abort_rd_data", int'(rd_data), 0);
      chk("abort_cmd_ready", int'(cmd_ready), 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      issue({2'b01, 8'h00});
      issue({2'b11, 8'hC3});
      issue({2'b01, 8'h00});
      wait_idle();
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
